// File: rtl/_1x16_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : _1x16_tdm_demux
// Description : 1:16 TDM demultiplexer / deserializer. It collects 16
//               qualified serial slots, starting at a frame_start marker, into
//               a shadow register. It publishes a completed word on dout with
//               a one-cycle dout_valid pulse. A frame_start that arrives
//               mid-frame discards the partial frame, pulses sync_err, and
//               restarts collection at slot 0.
// Revision    : 1.0 - initial release
// ============================================================================
module _1x16_tdm_demux #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        frame_start,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        sync_err,
    output logic [3:0]  slot,
    output logic [7:0]  frame_cnt
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;
    localparam logic [3:0] C_LAST_SLOT = 4'd15;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_slot;
    logic [3:0]  w_slot_nxt;
    logic [14:0] r_shadow;
    logic [14:0] w_shadow_nxt;
    logic [15:0] r_dout;
    logic [15:0] w_dout_nxt;
    logic        r_dout_valid;
    logic        w_dout_valid_nxt;
    logic        r_sync_err;
    logic        w_sync_err_nxt;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  w_frame_cnt_nxt;

    // The shadow register holds slots 0..14 in slot order. The live din
    // supplies slot 15, so the word is complete on the edge that accepts it.
    logic [15:0] w_frame;
    logic [15:0] w_word;

    assign w_frame = {din, r_shadow};

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_word = w_frame;
        end else begin : g_msb_first
            for (genvar i = 0; i < 16; i++) begin : g_bit
                assign w_word[15-i] = w_frame[i];
            end
        end
    endgenerate

    // Next-state and next-output decode. Nothing moves unless din_valid is high.
    always_comb begin
        w_state_nxt      = r_state;
        w_slot_nxt       = r_slot;
        w_shadow_nxt     = r_shadow;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;
        w_frame_cnt_nxt  = r_frame_cnt;
        if (din_valid) begin
            case (r_state)
                ST_IDLE: begin
                    // Without a frame marker, a bit has no slot position and is dropped.
                    if (frame_start) begin
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 4'd1;
                        w_state_nxt     = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (frame_start) begin
                        // Resynchronise: the partial frame is dropped and dout is left untouched.
                        w_sync_err_nxt  = 1'b1;
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 4'd1;
                    end else if (r_slot == C_LAST_SLOT) begin
                        w_dout_nxt       = w_word;
                        w_dout_valid_nxt = 1'b1;
                        w_frame_cnt_nxt  = r_frame_cnt + 8'd1;
                        w_slot_nxt       = 4'd0;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_shadow_nxt[r_slot] = din;
                        w_slot_nxt           = r_slot + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_slot_nxt  = 4'd0;
                end
            endcase
        end
    end

    // State and output registers. Reset has priority over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_slot       <= 4'd0;
            r_shadow     <= 15'd0;
            r_dout       <= 16'h0000;
            r_dout_valid <= 1'b0;
            r_sync_err   <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_shadow     <= w_shadow_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_sync_err   <= w_sync_err_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign sync_err   = r_sync_err;
    assign slot       = r_slot;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb__1x16_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb__1x16_tdm_demux
// Description : Directed self-checking bench for _1x16_tdm_demux. It drives
//               two instances (LSB_FIRST=1 and LSB_FIRST=0) from the same
//               serial stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb__1x16_tdm_demux;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        frame_start;
    logic [15:0] dout1;
    logic        dout_valid1;
    logic        sync_err1;
    logic [3:0]  slot1;
    logic [7:0]  frame_cnt1;
    logic [15:0] dout0;
    logic        dout_valid0;
    logic        sync_err0;
    logic [3:0]  slot0;
    logic [7:0]  frame_cnt0;

    int checks;
    int errors;
    int exp_fc;

    _1x16_tdm_demux #(.LSB_FIRST(1)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .dout       (dout1),
        .dout_valid (dout_valid1),
        .sync_err   (sync_err1),
        .slot       (slot1),
        .frame_cnt  (frame_cnt1)
    );

    _1x16_tdm_demux #(.LSB_FIRST(0)) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .dout       (dout0),
        .dout_valid (dout_valid0),
        .sync_err   (sync_err0),
        .slot       (slot0),
        .frame_cnt  (frame_cnt0)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15-i] = v[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1 ns after the rising edge.
    task automatic cyc(input logic d, input logic v, input logic fs);
        din         = d;
        din_valid   = v;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    // Send a frame. Bit k is word[k] when lsbf is set, else word[15-k].
    // With gaps set, each bit after the first is preceded by one invalid cycle
    // that carries a spurious frame_start. serr is the expected sync_err on slot 0.
    task automatic send_frame(input logic [15:0] word, input logic lsbf,
                              input logic gaps, input logic serr);
        logic [15:0] exp1;
        logic [3:0]  held;
        exp1 = lsbf ? word : rev16(word);
        for (int k = 0; k < 16; k++) begin
            if (gaps && k > 0) begin
                held = slot1;
                cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1);
                chk("gap_slot_hold", 16'(slot1), 16'(held));
                chk("gap_no_pulse", {14'd0, dout_valid1, sync_err1}, 16'd0);
            end
            cyc(lsbf ? word[k] : word[15-k], 1'b1, k == 0);
            if (k < 15) begin
                chk("slot_adv", 16'(slot1), 16'(k + 1));
                chk("no_dv_midframe", 16'(dout_valid1), 16'd0);
                chk("serr", 16'(sync_err1), 16'((k == 0) && serr));
            end else begin
                exp_fc = (exp_fc + 1) % 256;
                chk("dv_pulse", {14'd0, dout_valid1, sync_err1}, 16'b10);
                chk("dout_lsb", dout1, exp1);
                chk("dout_msb", dout0, rev16(exp1));
                chk("slot_end", 16'(slot1), 16'd0);
                chk("frame_cnt", 16'(frame_cnt1), 16'(exp_fc));
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_fc      = 0;
        rst         = 1'b1;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_dout", dout1, 16'h0000);
        chk("rst_flags", {14'd0, dout_valid1, sync_err1}, 16'd0);
        chk("rst_slot", 16'(slot1), 16'd0);
        chk("rst_fc", 16'(frame_cnt1), 16'd0);
        rst = 1'b0;

        // Valid bits in IDLE without frame_start are dropped.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("idle_drop_slot", 16'(slot1), 16'd0);
        chk("idle_drop_dv", 16'(dout_valid1), 16'd0);

        // A5C3, LSB first, continuous. The LSB_FIRST=0 instance sees the bit-reversed word.
        send_frame(16'hA5C3, 1'b1, 1'b0, 1'b0);
        chk("a5c3_lsb", dout1, 16'hA5C3);
        chk("a5c3_msb_inst", dout0, 16'hC3A5);
        cyc(1'b0, 1'b0, 1'b0);
        chk("dv_single", 16'(dout_valid1), 16'd0);
        chk("dout_hold", dout1, 16'hA5C3);

        // The same frame with a gap before every bit
        send_frame(16'hA5C3, 1'b1, 1'b1, 1'b0);
        chk("a5c3_gaps", dout1, 16'hA5C3);
        chk("fc_after_gaps", 16'(frame_cnt1), 16'd2);

        // Back-to-back frames with no idle cycle between them
        send_frame(16'h1234, 1'b1, 1'b0, 1'b0);
        send_frame(16'hFFFF, 1'b1, 1'b0, 1'b0);
        chk("b2b_dout", dout1, 16'hFFFF);

        // frame_start reasserted at slot 7
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, k == 0);
        chk("pre_sync_slot", 16'(slot1), 16'd7);
        send_frame(16'h0F0F, 1'b1, 1'b0, 1'b1);
        chk("after_sync", dout1, 16'h0F0F);

        // Reset at slot 10. Reset wins over valid input. No pulses afterwards.
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, k == 0);
        chk("pre_rst_slot", 16'(slot1), 16'd10);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        exp_fc = 0;
        chk("midrst_dout", dout1, 16'h0000);
        chk("midrst_fc", 16'(frame_cnt1), 16'd0);
        chk("midrst_slot", 16'(slot1), 16'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("midrst_flags", {14'd0, dout_valid1, sync_err1}, 16'd0);
        chk("midrst_need_fs", 16'(slot1), 16'd0);
        send_frame(16'h8001, 1'b1, 1'b0, 1'b0);
        chk("f8001_fc", 16'(frame_cnt1), 16'd1);

        // MSB-first streams, as received by the LSB_FIRST=0 instance
        send_frame(16'h8001, 1'b0, 1'b0, 1'b0);
        chk("msb_8001", dout0, 16'h8001);
        send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
        chk("msb_1234", dout0, 16'h1234);
        chk("msb_1234_lsb_inst", dout1, 16'h2C48);

        // 256 frames: frame_cnt wraps to 0.
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_fc = 0;
        for (int f = 0; f < 256; f++) begin
            send_frame(16'(f * 16'h0101 + 16'h5A), 1'b1, 1'b0, 1'b0);
            if (f == 254) chk("fc_255", 16'(frame_cnt1), 16'd255);
        end
        chk("fc_wrap", 16'(frame_cnt1), 16'd0);
        chk("fc_wrap_msb", 16'(frame_cnt0), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
